// File: rtl/if_prefetch_queue_if.sv
// rtl/if_prefetch_queue_if.sv - fetch-stage bundle: control inputs, instruction SRAM port, ID handshake
interface if_prefetch_queue_if;
   logic        stall;
   logic        br_e;
   logic [31:0] br_addr;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [64:0] if_to_id_bus;

   // Fetch stage side
   modport master (
      input  stall, br_e, br_addr, inst_sram_rdata, id_ready,
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output id_valid, id_pc, id_inst, if_to_id_bus
   );

   // Environment side: pipeline control, SRAM and ID stage
   modport slave (
      output stall, br_e, br_addr, inst_sram_rdata, id_ready,
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  id_valid, id_pc, id_inst, if_to_id_bus
   );
endinterface

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - sequential instruction prefetcher with DEPTH-entry {pc, inst} queue
module if_prefetch_queue #(
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input logic clk,
   input logic rst,
   if_prefetch_queue_if.master bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   pc_reg;
   logic [31:0]   req_pc;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          inflight;
   logic          started;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic [CW:0]   occupancy;
   logic          issue;
   logic          push;
   logic          pop;
   logic          head_valid;

   // Issue only when the queue can absorb every outstanding response
   always_comb begin
      occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
      head_valid = (count != '0);
      issue      = started & ~bus.stall & ~bus.br_e & (occupancy < DEPTH_W);
      push       = inflight & ~bus.br_e;
      pop        = head_valid & bus.id_ready & ~bus.br_e;
   end

   // Fetch control: pc, in-flight tracking, queue pointers; redirect wins over everything but reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg   <= RESET_PC;
         req_pc   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
         started  <= 1'b0;
      end else begin
         started <= 1'b1;
         if (bus.br_e) begin
            pc_reg   <= bus.br_addr;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
         end else begin
            inflight <= issue;
            if (issue) begin
               pc_reg <= pc_reg + PC_STEP;
               req_pc <= pc_reg;
            end
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Queue storage: SRAM data is only valid in the response cycle, so capture it then
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         pc_mem[wr_ptr]   <= req_pc;
         inst_mem[wr_ptr] <= bus.inst_sram_rdata;
      end
   end

   // Outputs; head fields are forced to zero when empty so reset leaves the ID bus clean
   always_comb begin
      bus.inst_sram_en    = issue;
      bus.inst_sram_wen   = 4'b0;
      bus.inst_sram_addr  = pc_reg;
      bus.inst_sram_wdata = 32'b0;
      bus.id_valid        = head_valid;
      bus.id_pc           = head_valid ? pc_mem[rd_ptr]   : 32'b0;
      bus.id_inst         = head_valid ? inst_mem[rd_ptr] : 32'b0;
      bus.if_to_id_bus    = {bus.id_valid, bus.id_pc, bus.id_inst};
   end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - scoreboard bench for if_prefetch_queue
module tb_if_prefetch_queue;
   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
   localparam int          DEPTH    = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_prefetch_queue_if bus ();

   if_prefetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .PC_STEP(32'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [63:0] sb [$];
   logic        m_started;
   logic        m_pend;
   logic [31:0] m_pc;
   logic [31:0] m_pend_pc;

   logic        obs_en;
   logic        obs_valid;
   logic [31:0] obs_addr;
   logic [31:0] obs_pc;
   logic [31:0] rdata_next;
   int          issues_seen;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_started = 1'b0;
      m_pend    = 1'b0;
      m_pc      = RESET_PC;
      m_pend_pc = 32'h0;
   endtask

   task automatic step();
      logic exp_en;
      logic exp_valid;
      @(negedge clk);
      obs_en    = bus.inst_sram_en;
      obs_addr  = bus.inst_sram_addr;
      obs_valid = bus.id_valid;
      obs_pc    = bus.id_pc;

      exp_en    = m_started && !bus.stall && !bus.br_e && ((sb.size() + int'(m_pend)) < DEPTH);
      exp_valid = (sb.size() != 0);
      chk("sram_en", obs_en, exp_en);
      chk("sram_addr", obs_addr, m_pc);
      chk("sram_wen_wdata", {bus.inst_sram_wen, bus.inst_sram_wdata}, 65'd0);
      chk("id_valid", obs_valid, exp_valid);
      if (exp_valid) begin
         chk("id_pc", bus.id_pc, sb[0][63:32]);
         chk("id_inst", bus.id_inst, sb[0][31:0]);
         chk("if_to_id_bus", bus.if_to_id_bus, {1'b1, sb[0]});
      end else begin
         chk("bus_valid_bit", bus.if_to_id_bus[64], 1'b0);
      end
      if (obs_en) issues_seen++;
      rdata_next = obs_en ? hash(obs_addr) : 32'hdead_beef;

      if (rst) begin
         model_reset();
      end else begin
         m_started = 1'b1;
         if (bus.br_e) begin
            sb.delete();
            m_pend = 1'b0;
            m_pc   = bus.br_addr;
         end else begin
            if (exp_valid && bus.id_ready) void'(sb.pop_front());
            if (m_pend) sb.push_back({m_pend_pc, hash(m_pend_pc)});
            m_pend = exp_en;
            if (exp_en) begin
               m_pend_pc = m_pc;
               m_pc      = m_pc + 32'd4;
            end
         end
      end

      @(posedge clk);
      #1;
      bus.inst_sram_rdata = rdata_next;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst                 = 1'b1;
      bus.stall           = 1'b0;
      bus.br_e            = 1'b0;
      bus.br_addr         = 32'h0;
      bus.id_ready        = 1'b1;
      bus.inst_sram_rdata = 32'h0;
      issues_seen         = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // reset state
      run(2);
      chk("reset_addr", obs_addr, RESET_PC);
      chk("reset_valid", obs_valid, 1'b0);

      // release reset, free-flowing fetch
      rst = 1'b0;
      run(1);
      chk("startup_no_issue", obs_en, 1'b0);
      run(1);
      chk("first_issue", {obs_en, obs_addr}, {1'b1, RESET_PC});
      run(12);

      // ID back-pressure fills the queue, then drains in order
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      bus.id_ready = 1'b0;
      issues_seen = 0;
      run(10);
      chk("fill_issue_count", issues_seen, 4);
      chk("fill_no_en", obs_en, 1'b0);
      chk("fill_head_pc", {obs_valid, obs_pc}, {1'b1, RESET_PC});
      chk("fill_next_addr", obs_addr, 32'hbfc0_0010);
      bus.id_ready = 1'b1;
      run(10);

      // redirect with 3 queued and 1 in flight
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      bus.id_ready = 1'b0;
      run(5);
      bus.br_e = 1'b1;
      bus.br_addr = 32'h8000_1000;
      run(1);
      bus.br_e = 1'b0;
      bus.id_ready = 1'b1;
      run(1);
      chk("redir_valid", obs_valid, 1'b0);
      chk("redir_issue", {obs_en, obs_addr}, {1'b1, 32'h8000_1000});
      run(2);
      chk("redir_head", {obs_valid, obs_pc}, {1'b1, 32'h8000_1000});
      run(6);

      // stall right after an issue
      bus.stall = 1'b1;
      issues_seen = 0;
      run(5);
      chk("stall_no_issue", issues_seen, 0);
      bus.stall = 1'b0;
      run(8);

      // random back-pressure and stalls: push/pop at the full boundary
      for (int i = 0; i < 60; i++) begin
         bus.id_ready = 1'($urandom_range(0, 1));
         bus.stall    = ($urandom_range(0, 5) == 0);
         step();
      end
      bus.id_ready = 1'b1;
      bus.stall = 1'b0;
      run(6);

      // 32-bit pc wrap
      bus.br_e = 1'b1;
      bus.br_addr = 32'hffff_fffc;
      run(1);
      bus.br_e = 1'b0;
      run(1);
      chk("wrap_first", {obs_en, obs_addr}, {1'b1, 32'hffff_fffc});
      run(1);
      chk("wrap_second", {obs_en, obs_addr}, {1'b1, 32'h0000_0000});
      run(4);

      // reset mid-stream with stall and a request in flight
      bus.stall = 1'b1;
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      bus.stall = 1'b0;
      run(1);
      chk("midrst_valid", obs_valid, 1'b0);
      chk("midrst_state", {obs_en, obs_addr}, {1'b0, RESET_PC});
      run(1);
      chk("midrst_restart", {obs_en, obs_addr}, {1'b1, RESET_PC});
      run(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised next-generation instruction-fetch stage.
- Issues sequential fetches to a synchronous instruction SRAM with 1-cycle read latency and buffers the returned {pc, inst} pairs in a DEPTH-entry FIFO.
- The FIFO feeds ID through a valid/ready handshake, so ID back-pressure no longer stalls the SRAM port directly.
- A branch redirect squashes all queued and in-flight fetches and restarts fetching at the target.

Parameters:
- RESET_PC, 32'hbfc0_0000: first fetch address after reset.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  global IF stall (stall[0] of the stall bus); blocks new issues only
- br_e  in  1  redirect valid, one-cycle pulse from EX
- br_addr  in  32  redirect target
- inst_sram_en  out  1  fetch request this cycle
- inst_sram_wen  out  4  constant 4'b0
- inst_sram_addr  out  32  fetch address (= pc_reg)
- inst_sram_wdata  out  32  constant 32'b0
- inst_sram_rdata  in  32  read data, valid the cycle after inst_sram_en
- id_valid  out  1  FIFO head valid
- id_ready  in  1  ID accepts head
- id_pc  out  32  head PC
- id_inst  out  32  head instruction
- if_to_id_bus  out  65  {id_valid, id_pc, id_inst}

Behaviour:
- Reset (synchronous):
  - pc_reg=RESET_PC, FIFO empty (rd_ptr=wr_ptr=0, count=0), inflight=0, started=0.
  - All outputs 0 during reset, except inst_sram_addr=RESET_PC.
- started sets to 1 on the first clock after rst deasserts. No issue occurs in that cycle, matching the 1-cycle startup of the previous IF.
- Issue condition:
  - issue = started & !stall & !br_e & (count + inflight < DEPTH).
  - inst_sram_en = issue.
  - On issue: pc_reg <= pc_reg + PC_STEP (32-bit wrap, no trap); req_pc <= pc_reg; inflight <= 1.
  - Otherwise inflight <= 0.
  - At most one request is in flight. A new issue may occur every cycle: a response and an issue in the same cycle is legal.
- Response capture: when inflight=1 and no br_e, push {req_pc, inst_sram_rdata} at wr_ptr. The space reservation in the issue condition guarantees the FIFO never overflows. Data is not otherwise held.
- Pop: id_valid = (count != 0). Pop when id_valid & id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - id_pc and id_inst are driven from the head entry combinationally off registers; they are don't-care when id_valid=0.
- Redirect (br_e=1), highest priority:
  - pc_reg <= br_addr; FIFO flushed (count=0, pointers reset); inflight <= 0.
  - The response arriving in the br_e cycle is discarded.
  - No issue and no pop in the br_e cycle.
  - Next cycle: fetch br_addr if !stall.
  - br_e during stall still redirects and flushes.
- Stall:
  - stall=1 blocks issue only.
  - An in-flight response is still captured.
  - Pops continue.
  - pc_reg holds.
- Throughput: 1 inst/cycle sustained when id_ready=1, since the FIFO refills every cycle and count+inflight stays below DEPTH.
- Latency:
  - Address issued at cycle t.
  - Entry visible on id_valid at cycle t+2: rdata at t+1, pushed at the t+1 edge, head valid from t+2.
- Reset mid-operation clears everything regardless of br_e, stall or inflight.

Test Plan:
- Reset release, id_ready=1, stall=0:
  - First inst_sram_en one cycle after rst drops, with addr 32'hbfc0_0000.
  - Subsequent addrs 0xbfc00004, 0xbfc00008…
  - id_pc sequence matches, with the first id_valid 2 cycles after the first issue.
- id_ready=0 held, stall=0, DEPTH=4:
  - Exactly 4 issues total; count=4 and inst_sram_en=0 thereafter.
  - Raise id_ready: entries pop in order, then issue resumes at 0xbfc00010.
- Redirect: br_e=1 with br_addr=0x8000_1000 while 3 entries are queued and 1 is in flight:
  - Next cycle id_valid=0 and inst_sram_addr=0x80001000 with en=1.
  - The in-flight data never appears at ID.
  - Next id_pc=0x80001000.
- stall=1 for 5 cycles immediately after an issue:
  - The in-flight response is still pushed; no new en.
  - pc_reg holds, and fetching continues sequentially after the stall.
- Simultaneous push and pop when count=DEPTH-1 with id_ready=1: count holds, no overflow, in-order data.
- Wrap: br_addr=0xffff_fffc → next fetch addr 0x0000_0000.
- rst asserted mid-stream with stall=1 and inflight=1:
  - Outputs clear next cycle, FIFO empty.
  - Restart at RESET_PC.
